// File: rtl/ct_ct_sub_if.sv
// Handshake/data bundle for the sequential ciphertext subtractor.
// A ciphertext is carried as a packed [1:0][N-1:0][W-1:0] array:
// index 0 is polynomial A, index 1 is polynomial B.
//   in_valid/in_ready     : operand handshake (in_ct1 minuend, in_ct2 subtrahend)
//   out_valid/out_ready   : result handshake (out_ct registered result)
//   busy                  : block is working on or holding a job
// Modports: master = environment (producer + consumer), slave = the subtractor.
interface ct_ct_sub_if #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 16
) ();
    logic                           in_valid;
    logic                           in_ready;
    logic [1:0][N-1:0][W-1:0]       in_ct1;
    logic [1:0][N-1:0][W-1:0]       in_ct2;
    logic                           out_valid;
    logic                           out_ready;
    logic [1:0][N-1:0][W-1:0]       out_ct;
    logic                           busy;

    modport master (
        output in_valid, in_ct1, in_ct2, out_ready,
        input  in_ready, out_valid, out_ct, busy
    );

    modport slave (
        input  in_valid, in_ct1, in_ct2, out_ready,
        output in_ready, out_valid, out_ct, busy
    );
endinterface

// File: rtl/ct_ct_sub_seq.sv
// Sequential modular ciphertext subtractor: out_ct = (in_ct1 - in_ct2) mod QP,
// coefficient-wise on both polynomials A and B, LANES coefficients of each per cycle.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : ct_ct_sub_if.slave (in_valid/in_ready/in_ct1/in_ct2,
//            out_valid/out_ready/out_ct, busy)
// Operands are latched on acceptance; the result is held in out_ct until consumed.
module ct_ct_sub_seq #(
    parameter int unsigned    N     = 8,
    parameter int unsigned    W     = 16,
    parameter logic [W-1:0]   QP    = W'(65521),
    parameter int unsigned    LANES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ct_ct_sub_if.slave    bus
);

    localparam int unsigned Groups = N / LANES;
    localparam int unsigned IdxW   = (Groups > 1) ? $clog2(Groups) : 1;
    localparam int unsigned KW     = (N > 1) ? $clog2(N) : 1;

    if ((N % LANES) != 0) begin : g_lanes_check
        $error("ct_ct_sub_seq: N must be a multiple of LANES");
    end

    typedef logic [1:0][N-1:0][W-1:0] ct_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    ct_t             op1_q, op1_d;
    ct_t             op2_q, op2_d;
    ct_t             out_q, out_d;
    logic [KW-1:0]   k;

    // Single conditional correction: add QP back only when the difference wrapped.
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        logic [W:0] dc;
        d  = {1'b0, a} - {1'b0, b};
        dc = d + {1'b0, QP};
        if (a >= b) begin
            return d[W-1:0];
        end
        return dc[W-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        out_d   = out_q;
        k       = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    op1_d   = bus.in_ct1;
                    op2_d   = bus.in_ct2;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int unsigned j = 0; j < LANES; j++) begin
                    k           = KW'(32'(idx_q) * LANES + j);
                    out_d[0][k] = sub_mod(op1_q[0][k], op2_q[0][k]);
                    out_d[1][k] = sub_mod(op1_q[1][k], op2_q[1][k]);
                end
                if (idx_q == IdxW'(Groups - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            out_q   <= out_d;
        end
    end

    // Pure decodes of registered state: no path from in_valid/out_ready to outputs.
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_ct    = out_q;

endmodule

// File: tb/tb_ct_ct_sub_seq.sv
module tb_ct_ct_sub_seq;

    localparam int unsigned  N  = 8;
    localparam int unsigned  W  = 16;
    localparam int unsigned  KW = $clog2(N);
    localparam logic [W-1:0] QP = 16'd65521;

    typedef logic [1:0][N-1:0][W-1:0] ct_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ct_ct_sub_if #(.N(N), .W(W)) ifa ();
    ct_ct_sub_if #(.N(N), .W(W)) ifb ();

    ct_ct_sub_seq #(.N(N), .W(W), .QP(QP), .LANES(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    ct_ct_sub_seq #(.N(N), .W(W), .QP(QP), .LANES(8)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    int  total = 0;
    int  bad   = 0;
    ct_t exp_a[$];
    ct_t exp_b[$];

    // Reference: mathematical (a - b) mod q on plain integers.
    function automatic logic [W-1:0] ref_coef(input int a, input int b);
        int r;
        r = (a - b) % int'(QP);
        if (r < 0) r = r + int'(QP);
        return W'(r);
    endfunction

    function automatic ct_t ref_ct(input ct_t x, input ct_t y);
        ct_t r;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++)
                r[1'(p)][KW'(i)] = ref_coef(int'(x[1'(p)][KW'(i)]), int'(y[1'(p)][KW'(i)]));
        return r;
    endfunction

    function automatic ct_t rand_ct();
        ct_t r;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++)
                r[1'(p)][KW'(i)] = W'($urandom_range(int'(QP) - 1, 0));
        return r;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_ct(input string name, input ct_t got, input ct_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Scoreboard monitors: compare whenever a result handshake is about to occur.
    always @(negedge clk) begin
        if (rst_n && ifa.out_valid && ifa.out_ready) begin
            if (exp_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_a: unexpected result got %h", ifa.out_ct);
            end else begin
                check_ct("sb_a", ifa.out_ct, exp_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ifb.out_valid && ifb.out_ready) begin
            if (exp_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_b: unexpected result got %h", ifb.out_ct);
            end else begin
                check_ct("sb_b", ifb.out_ct, exp_b.pop_front());
            end
        end
    end

    // One job on the LANES=2 instance; called #1 after a rising edge with the block idle.
    task automatic job_a(input ct_t c1, input ct_t c2, input int hold, input bit scramble);
        ct_t snap;
        ifa.in_ct1    = c1;
        ifa.in_ct2    = c2;
        ifa.in_valid  = 1'b1;
        ifa.out_ready = scramble;
        @(posedge clk);                       // E0
        exp_a.push_back(ref_ct(c1, c2));
        #1;
        ifa.in_valid = scramble;
        check_bit("run_in_ready", ifa.in_ready, 1'b0);
        check_bit("run_busy", ifa.busy, 1'b1);
        for (int c = 1; c < 4; c++) begin
            if (scramble) begin
                ifa.in_ct1 = rand_ct();
                ifa.in_ct2 = rand_ct();
            end
            @(posedge clk);                   // E1..E3
            #1;
            check_bit("latency_no_valid", ifa.out_valid, 1'b0);
            check_bit("latency_busy", ifa.busy, 1'b1);
        end
        ifa.out_ready = 1'b0;
        @(posedge clk);                       // E4
        #1;
        check_bit("latency_valid", ifa.out_valid, 1'b1);
        check_bit("done_in_ready", ifa.in_ready, 1'b0);
        snap = ifa.out_ct;
        for (int h = 0; h < hold; h++) begin
            ifa.in_valid = 1'b1;
            ifa.in_ct1   = rand_ct();
            ifa.in_ct2   = rand_ct();
            @(posedge clk);
            #1;
            check_bit("bp_valid", ifa.out_valid, 1'b1);
            check_bit("bp_in_ready", ifa.in_ready, 1'b0);
            check_ct("bp_stable", ifa.out_ct, snap);
        end
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        @(posedge clk);                       // Eh
        #1;
        ifa.out_ready = 1'b0;
        check_bit("hs_valid_low", ifa.out_valid, 1'b0);
        check_bit("hs_in_ready", ifa.in_ready, 1'b1);
        check_bit("hs_busy", ifa.busy, 1'b0);
    endtask

    initial begin
        ct_t c1, c2, nxt;

        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b0;
        ifa.in_ct1    = '0;
        ifa.in_ct2    = '0;
        ifb.in_valid  = 1'b0;
        ifb.out_ready = 1'b0;
        ifb.in_ct1    = '0;
        ifb.in_ct2    = '0;

        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_in_ready", ifa.in_ready, 1'b1);
        check_bit("rst_out_valid", ifa.out_valid, 1'b0);
        check_bit("rst_busy", ifa.busy, 1'b0);
        check_ct("rst_out_ct", ifa.out_ct, '0);
        check_bit("rst_b_in_ready", ifb.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed boundary coefficients.
        c1 = rand_ct();
        c2 = rand_ct();
        c1[0][0] = 16'd5;     c2[0][0] = 16'd3;
        c1[0][1] = 16'd3;     c2[0][1] = 16'd5;
        c1[1][0] = 16'd0;     c2[1][0] = 16'd65520;
        c1[1][1] = 16'd65520; c2[1][1] = 16'd0;
        c1[0][2] = 16'd1234;  c2[0][2] = 16'd1234;
        c1[1][7] = 16'd65520; c2[1][7] = 16'd65520;
        job_a(c1, c2, 0, 1'b0);
        check_int("dir_a0", int'(ifa.out_ct[0][0]), 2);
        check_int("dir_a1", int'(ifa.out_ct[0][1]), 65519);
        check_int("dir_b0", int'(ifa.out_ct[1][0]), 1);
        check_int("dir_b1", int'(ifa.out_ct[1][1]), 65520);
        check_int("dir_eq", int'(ifa.out_ct[0][2]), 0);
        check_int("dir_eq_max", int'(ifa.out_ct[1][7]), 0);

        // Backpressure for 10 cycles with changing inputs and in_valid high.
        job_a(rand_ct(), rand_ct(), 10, 1'b1);

        // Randomized jobs with random stall and operand scrambling.
        for (int t = 0; t < 6; t++)
            job_a(rand_ct(), rand_ct(), int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));

        // Reset in the middle of RUN aborts the job.
        ifa.in_ct1   = rand_ct();
        ifa.in_ct2   = rand_ct();
        ifa.in_valid = 1'b1;
        @(posedge clk);                       // E0
        #1;
        ifa.in_valid = 1'b0;
        @(posedge clk);                       // E1
        @(posedge clk);                       // E2
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("mid_rst_out_valid", ifa.out_valid, 1'b0);
        check_bit("mid_rst_in_ready", ifa.in_ready, 1'b1);
        check_bit("mid_rst_busy", ifa.busy, 1'b0);
        check_ct("mid_rst_out_ct", ifa.out_ct, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        job_a(rand_ct(), rand_ct(), 1, 1'b0);

        // LANES=8 instance: single RUN cycle, back-to-back jobs every 3 cycles.
        ifb.out_ready = 1'b1;
        nxt           = rand_ct();
        c2            = rand_ct();
        ifb.in_ct1    = nxt;
        ifb.in_ct2    = c2;
        ifb.in_valid  = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check_bit("b2b_in_ready", ifb.in_ready, 1'b1);
            @(posedge clk);                   // acceptance
            exp_b.push_back(ref_ct(nxt, c2));
            #1;
            check_bit("b2b_run_in_ready", ifb.in_ready, 1'b0);
            check_bit("b2b_run_busy", ifb.busy, 1'b1);
            if (j < 3) begin
                nxt        = rand_ct();
                c2         = rand_ct();
                ifb.in_ct1 = nxt;
                ifb.in_ct2 = c2;
            end else begin
                ifb.in_valid = 1'b0;
            end
            @(posedge clk);                   // E1
            #1;
            check_bit("b2b_valid_e1", ifb.out_valid, 1'b1);
            @(posedge clk);                   // handshake
            #1;
            check_bit("b2b_valid_low", ifb.out_valid, 1'b0);
        end
        ifb.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_int("sb_a_drained", exp_a.size(), 0);
        check_int("sb_b_drained", exp_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
